// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - E-stage multiply/divide unit bus: op, operands, HI/LO and stall status
interface mdu_if;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    modport master (
        output md_op, a, b,
        input  start, busy, hi, lo, md_out
    );

    modport slave (
        input  md_op, a, b,
        output start, busy, hi, lo, md_out
    );
endinterface

// File: rtl/mdu.sv
// rtl/mdu.sv - fixed-latency multiply/divide unit holding the MIPS HI/LO registers
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   res_hi, res_lo;
    logic          res_dz;
    logic [31:0]   hi_q, lo_q;

    logic          is_md;
    logic [63:0]   smul, umul;
    logic [31:0]   abs_a, abs_b, div_a, div_b, uq, ur;
    logic [31:0]   calc_hi, calc_lo;
    logic          calc_dz;

    assign is_md     = (bus.md_op >= OP_MULT) && (bus.md_op <= OP_DIVU);
    assign bus.busy  = (state == RUN);
    assign bus.start = is_md && !bus.busy;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

    always_comb begin
        bus.md_out = 32'd0;
        if (bus.md_op == OP_MFHI)
            bus.md_out = hi_q;
        else if (bus.md_op == OP_MFLO)
            bus.md_out = lo_q;
    end

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    always_comb begin
        smul    = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        umul    = {32'd0, bus.a} * {32'd0, bus.b};
        abs_a   = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
        abs_b   = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
        div_a   = (bus.md_op == OP_DIV) ? abs_a : bus.a;
        div_b   = (bus.md_op == OP_DIV) ? abs_b : bus.b;
        if (div_b == 32'd0)
            div_b = 32'd1;
        uq      = div_a / div_b;
        ur      = div_a % div_b;
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        calc_dz = 1'b0;
        case (bus.md_op)
            OP_MULT:  {calc_hi, calc_lo} = smul;
            OP_MULTU: {calc_hi, calc_lo} = umul;
            OP_DIV: begin
                calc_lo = (bus.a[31] ^ bus.b[31]) ? (~uq + 32'd1) : uq;
                calc_hi = bus.a[31] ? (~ur + 32'd1) : ur;
                calc_dz = (bus.b == 32'd0);
            end
            OP_DIVU: begin
                calc_lo = uq;
                calc_hi = ur;
                calc_dz = (bus.b == 32'd0);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = RUN;
            RUN:  if (cnt == CW'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_dz <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (bus.start) begin
                res_hi <= calc_hi;
                res_lo <= calc_lo;
                res_dz <= calc_dz;
                cnt    <= (bus.md_op == OP_MULT || bus.md_op == OP_MULTU)
                          ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1) && !res_dz) begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
            end
            // Moves to HI/LO are only honoured while idle; stall logic keeps them out of RUN.
            if (state == IDLE && bus.md_op == OP_MTHI)
                hi_q <= bus.a;
            if (state == IDLE && bus.md_op == OP_MTLO)
                lo_q <= bus.a;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - directed self-checking bench for the multiply/divide unit
module tb_mdu;
    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3, DIVU = 4'd4;
    localparam logic [3:0] MTHI = 4'd5, MTLO = 4'd6, MFHI = 4'd7, MFLO = 4'd8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mdu_if m ();

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (m.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        m.md_op = op;
        m.a     = av;
        m.b     = bv;
        #1;
    endtask

    task automatic test_reset;
        m.md_op = NOP; m.a = 32'd0; m.b = 32'd0;
        step(NOP, 0, 0);
        step(NOP, 0, 0);
        reset = 1'b0;
        step(NOP, 0, 0);
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", m.busy); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", m.hi); end
        checks++; if (m.lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", m.lo); end
        checks++; if (m.start !== 1'b0) begin errors++; $display("FAIL reset_start got %h want 0", m.start); end
        checks++; if (m.md_out !== 32'd0) begin errors++; $display("FAIL reset_md_out got %h want 0", m.md_out); end
    endtask

    task automatic test_mult;
        step(MULT, 32'hFFFFFFFE, 32'd3);
        checks++; if (m.start !== 1'b1) begin errors++; $display("FAIL mult_start got %h want 1", m.start); end
        for (int i = 1; i <= 5; i++) begin
            step(NOP, 0, 0);
            checks++; if (m.busy !== 1'b1) begin errors++; $display("FAIL mult_busy_c%0d got %h want 1", i, m.busy); end
        end
        step(MFHI, 0, 0);
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL mult_done_busy got %h want 0", m.busy); end
        checks++; if (m.md_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_mfhi got %h want ffffffff", m.md_out); end
        checks++; if (m.lo !== 32'hFFFFFFFA) begin errors++; $display("FAIL mult_lo got %h want fffffffa", m.lo); end

        step(MULTU, 32'hFFFFFFFE, 32'd3);
        for (int i = 1; i <= 5; i++) step(NOP, 0, 0);
        step(MFLO, 0, 0);
        checks++; if (m.hi !== 32'h00000002) begin errors++; $display("FAIL multu_hi got %h want 00000002", m.hi); end
        checks++; if (m.md_out !== 32'hFFFFFFFA) begin errors++; $display("FAIL multu_mflo got %h want fffffffa", m.md_out); end
    endtask

    task automatic test_div;
        int nbusy;
        step(DIV, 32'hFFFFFFF9, 32'd2);
        nbusy = 0;
        for (int i = 1; i <= 12; i++) begin
            step(NOP, 0, 0);
            if (m.busy === 1'b1) nbusy++;
        end
        checks++; if (nbusy != 10) begin errors++; $display("FAIL div_busy_len got %0d want 10", nbusy); end
        checks++; if (m.lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", m.lo); end
        checks++; if (m.hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", m.hi); end

        step(DIVU, 32'd7, 32'd2);
        for (int i = 1; i <= 10; i++) step(NOP, 0, 0);
        step(NOP, 0, 0);
        checks++; if (m.lo !== 32'd3) begin errors++; $display("FAIL divu_lo got %h want 3", m.lo); end
        checks++; if (m.hi !== 32'd1) begin errors++; $display("FAIL divu_hi got %h want 1", m.hi); end

        step(DIV, 32'h80000000, 32'hFFFFFFFF);
        for (int i = 1; i <= 10; i++) step(NOP, 0, 0);
        step(NOP, 0, 0);
        checks++; if (m.lo !== 32'h80000000) begin errors++; $display("FAIL div_ovf_lo got %h want 80000000", m.lo); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL div_ovf_hi got %h want 0", m.hi); end
    endtask

    task automatic test_div_zero;
        int nbusy;
        step(MTHI, 32'h12345678, 0);
        step(MFHI, 0, 0);
        checks++; if (m.md_out !== 32'h12345678) begin errors++; $display("FAIL mthi_md_out got %h want 12345678", m.md_out); end
        step(DIV, 32'd55, 32'd0);
        nbusy = 0;
        for (int i = 1; i <= 12; i++) begin
            step(NOP, 0, 0);
            if (m.busy === 1'b1) nbusy++;
        end
        checks++; if (nbusy != 10) begin errors++; $display("FAIL divz_busy_len got %0d want 10", nbusy); end
        checks++; if (m.hi !== 32'h12345678) begin errors++; $display("FAIL divz_hi got %h want 12345678", m.hi); end
        checks++; if (m.lo !== 32'h80000000) begin errors++; $display("FAIL divz_lo got %h want 80000000", m.lo); end
    endtask

    task automatic test_busy_ignore;
        step(MULT, 32'd3, 32'd4);
        step(NOP, 32'd9, 32'd9);
        step(MULT, 32'd5, 32'd5);
        checks++; if (m.start !== 1'b0) begin errors++; $display("FAIL busy_start got %h want 0", m.start); end
        checks++; if ((m.start | m.busy) !== 1'b1) begin errors++; $display("FAIL busy_stall got %h want 1", m.start | m.busy); end
        step(MTLO, 32'hDEADBEEF, 0);
        step(NOP, 0, 0);
        checks++; if (m.lo !== 32'h80000000) begin errors++; $display("FAIL busy_mtlo_lo got %h want 80000000", m.lo); end
        step(NOP, 0, 0);
        checks++; if (m.busy !== 1'b1) begin errors++; $display("FAIL busy_c5 got %h want 1", m.busy); end
        step(NOP, 0, 0);
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL busy_c6 got %h want 0", m.busy); end
        checks++; if (m.lo !== 32'd12) begin errors++; $display("FAIL busy_res_lo got %h want 0000000c", m.lo); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL busy_res_hi got %h want 0", m.hi); end
    endtask

    task automatic test_back_to_back;
        step(MULTU, 32'hFFFFFFFF, 32'd2);
        for (int i = 1; i <= 5; i++) step(NOP, 0, 0);
        step(MULT, 32'd2, 32'd3);
        checks++; if (m.start !== 1'b1) begin errors++; $display("FAIL b2b_start got %h want 1", m.start); end
        checks++; if (m.hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %h want 1", m.hi); end
        checks++; if (m.lo !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_lo got %h want fffffffe", m.lo); end
        for (int i = 1; i <= 5; i++) step(NOP, 0, 0);
        step(MFLO, 0, 0);
        checks++; if (m.md_out !== 32'd6) begin errors++; $display("FAIL b2b_second_lo got %h want 6", m.md_out); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL b2b_second_hi got %h want 0", m.hi); end
    endtask

    task automatic test_reset_mid;
        step(DIV, 32'd100, 32'd7);
        for (int i = 1; i <= 3; i++) step(NOP, 0, 0);
        reset = 1'b1;
        #1;
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %h want 0", m.busy); end
        checks++; if (m.lo !== 32'd0) begin errors++; $display("FAIL rmid_lo got %h want 0", m.lo); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL rmid_hi got %h want 0", m.hi); end
        step(NOP, 0, 0);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) step(NOP, 0, 0);
        checks++; if (m.busy !== 1'b0) begin errors++; $display("FAIL rmid_after_busy got %h want 0", m.busy); end
        checks++; if (m.lo !== 32'd0) begin errors++; $display("FAIL rmid_after_lo got %h want 0", m.lo); end
        checks++; if (m.hi !== 32'd0) begin errors++; $display("FAIL rmid_after_hi got %h want 0", m.hi); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
